// File: rtl/systolic_feeder_if.sv
// Host load path and array-side stream bundle for systolic_feeder.
// master: host/array side; slave: the feeder itself.
interface systolic_feeder_if #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
);
  localparam int unsigned IDX_W = $clog2(DIM);

  logic                      ld_en;
  logic                      ld_sel;
  logic [IDX_W-1:0]          ld_idx;
  logic signed [BITS_AB-1:0] ld_data [DIM];
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      en_out;
  logic signed [BITS_AB-1:0] A_out [DIM];
  logic signed [BITS_AB-1:0] B_out [DIM];

  modport master (
    output ld_en, ld_sel, ld_idx, ld_data, start,
    input  busy, done, en_out, A_out, B_out
  );

  modport slave (
    input  ld_en, ld_sel, ld_idx, ld_data, start,
    output busy, done, en_out, A_out, B_out
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one A and one B matrix and streams them diagonally skewed into a
// DIM x DIM systolic MAC array, holding the array enable for the full
// propagation window (3*DIM-2 cycles).
// Optional: define SYSTOLIC_FEEDER_AUTOCLR_EN to clear both buffers in the
// DONE cycle, so an un-reloaded repeat start streams zeros.
module systolic_feeder #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input logic             clk,
  input logic             rst_n,
  systolic_feeder_if.slave bus
);
  localparam int unsigned FEED_LEN = 3 * DIM - 2;
  localparam int unsigned LAST_T   = FEED_LEN - 1;
  localparam int unsigned CNT_W    = $clog2(3 * DIM - 1);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          t;
  logic [CNT_W-1:0]          t_nxt;
  logic signed [BITS_AB-1:0] amem [DIM][DIM];
  logic signed [BITS_AB-1:0] bmem [DIM][DIM];
  logic signed [BITS_AB-1:0] a_nxt [DIM];
  logic signed [BITS_AB-1:0] b_nxt [DIM];
  logic signed [BITS_AB-1:0] a_q [DIM];
  logic signed [BITS_AB-1:0] b_q [DIM];
  logic                      busy_q;
  logic                      done_q;
  logic                      en_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.en_out = en_q;
  assign bus.A_out  = a_q;
  assign bus.B_out  = b_q;

  // Skewed data for the feed cycle about to be presented: row i / column j
  // carry the element whose two indices sum to that cycle number.
  always_comb begin
    t_nxt = (state == FEED) ? t + CNT_W'(1) : '0;
    for (int i = 0; i < int'(DIM); i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
    end
    for (int i = 0; i < int'(DIM); i++) begin
      for (int k = 0; k < int'(DIM); k++) begin
        if (int'(t_nxt) == i + k) begin
          a_nxt[i] = amem[i][k];
          b_nxt[i] = bmem[k][i];
        end
      end
    end
  end

  // Control FSM, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      t      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      en_q   <= 1'b0;
      for (int i = 0; i < int'(DIM); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        for (int k = 0; k < int'(DIM); k++) begin
          amem[i][k] <= '0;
          bmem[i][k] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.ld_en) begin
            // A load in the same cycle as start wins; start is dropped.
            for (int k = 0; k < int'(DIM); k++) begin
              if (bus.ld_sel) bmem[bus.ld_idx][k] <= bus.ld_data[k];
              else            amem[bus.ld_idx][k] <= bus.ld_data[k];
            end
          end else if (bus.start) begin
            state  <= FEED;
            t      <= '0;
            busy_q <= 1'b1;
            en_q   <= 1'b1;
            for (int i = 0; i < int'(DIM); i++) begin
              a_q[i] <= a_nxt[i];
              b_q[i] <= b_nxt[i];
            end
          end
        end
        FEED: begin
          if (t == CNT_W'(LAST_T)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b1;
            for (int i = 0; i < int'(DIM); i++) begin
              a_q[i] <= '0;
              b_q[i] <= '0;
            end
          end else begin
            t <= t_nxt;
            for (int i = 0; i < int'(DIM); i++) begin
              a_q[i] <= a_nxt[i];
              b_q[i] <= b_nxt[i];
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
`ifdef SYSTOLIC_FEEDER_AUTOCLR_EN
          for (int i = 0; i < int'(DIM); i++) begin
            for (int k = 0; k < int'(DIM); k++) begin
              amem[i][k] <= '0;
              bmem[i][k] <= '0;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: each feed pushes its expected
// per-cycle outputs from a reference buffer model, then pops and compares.
module tb_systolic_feeder;
  localparam int BW       = 8;
  localparam int DIM      = 8;
  localparam int FEED_LEN = 3 * DIM - 2;
  localparam int VW       = DIM * BW;

  typedef struct packed {
    logic          busy;
    logic          en;
    logic          done;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.BITS_AB(BW), .DIM(DIM)) bus ();
  systolic_feeder #(.BITS_AB(BW), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t             exp_q [$];
  obs_t             strm [FEED_LEN+1];
  logic signed [7:0] ma [DIM][DIM];
  logic signed [7:0] mb [DIM][DIM];
  logic signed [7:0] row [DIM];
  int errors = 0;
  int checks = 0;
  int en_cnt;
  int done_cnt;

  function automatic obs_t sample();
    obs_t s;
    s      = '0;
    s.busy = bus.busy;
    s.en   = bus.en_out;
    s.done = bus.done;
    for (int i = 0; i < DIM; i++) begin
      s.a[i*BW +: BW] = bus.A_out[i];
      s.b[i*BW +: BW] = bus.B_out[i];
    end
    return s;
  endfunction

  // Reference skew: A_out[i] = A[i][t-i], B_out[j] = B[t-j][j] when in range.
  function automatic obs_t model(input int t);
    obs_t m;
    int   d;
    m      = '0;
    m.busy = 1'b1;
    m.en   = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      d = t - i;
      if (d >= 0 && d < DIM) begin
        m.a[i*BW +: BW] = ma[i][d];
        m.b[i*BW +: BW] = mb[d][i];
      end
    end
    return m;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin
        ma[i][k] = '0;
        mb[i][k] = '0;
      end
  endtask

  task automatic push_feed();
    obs_t d;
    for (int t = 0; t < FEED_LEN; t++) exp_q.push_back(model(t));
    d      = '0;
    d.done = 1'b1;
    exp_q.push_back(d);
`ifdef SYSTOLIC_FEEDER_AUTOCLR_EN
    clear_model();
`endif
  endtask

  // Called at a negedge with the DUT idle.
  task automatic load_row(input logic sel, input int idx, input logic signed [7:0] r [DIM]);
    bus.ld_en  = 1'b1;
    bus.ld_sel = sel;
    bus.ld_idx = 3'(idx);
    for (int k = 0; k < DIM; k++) begin
      bus.ld_data[k] = r[k];
      if (sel) mb[idx][k] = r[k];
      else     ma[idx][k] = r[k];
    end
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // Start a feed at the current negedge and score every cycle through DONE.
  // poke >= 0 drives start plus an A row 0 load of 0x7F at that cycle.
  task automatic run_feed(input int poke);
    obs_t got, exp;
    push_feed();
    en_cnt   = 0;
    done_cnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    for (int idx = 0; idx <= FEED_LEN; idx++) begin
      bus.start = 1'b0;
      bus.ld_en = 1'b0;
      if (idx == poke) begin
        bus.start  = 1'b1;
        bus.ld_en  = 1'b1;
        bus.ld_sel = 1'b0;
        bus.ld_idx = '0;
        for (int k = 0; k < DIM; k++) bus.ld_data[k] = 8'sh7F;
      end
      got = sample();
      exp = exp_q.pop_front();
      strm[idx] = got;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream idx=%0d got=%h exp=%h", idx, got, exp);
      end
      if (got.en)   en_cnt++;
      if (got.done) done_cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) row[k] = (i == k) ? 8'sd1 : 8'sd0;
      load_row(1'b0, i, row);
    end
    for (int kk = 0; kk < DIM; kk++) begin
      for (int j = 0; j < DIM; j++) row[j] = 8'(8 * kk + j);
      load_row(1'b1, kk, row);
    end
    run_feed(-1);
    checks++;
    if (en_cnt != FEED_LEN) begin errors++; $display("FAIL en_count got=%0d exp=%0d", en_cnt, FEED_LEN); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (strm[FEED_LEN].done !== 1'b1 || strm[FEED_LEN].busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle done=%b busy=%b exp done=1 busy=0", strm[FEED_LEN].done, strm[FEED_LEN].busy);
    end
    checks++;
    if (strm[3].b[0 +: BW] !== 8'd24) begin errors++; $display("FAIL t3_b0 got=%0d exp=24", strm[3].b[0 +: BW]); end
    checks++;
    if (strm[3].a[0 +: BW] !== 8'd0) begin errors++; $display("FAIL t3_a0 got=%0d exp=0", strm[3].a[0 +: BW]); end
    checks++;
    if (strm[10].b[7*BW +: BW] !== 8'd31) begin errors++; $display("FAIL t10_b7 got=%0d exp=31", strm[10].b[7*BW +: BW]); end
    checks++;
    if (strm[0].busy !== 1'b1 || strm[0].en !== 1'b1) begin
      errors++;
      $display("FAIL first_cycle busy=%b en=%b exp 1 1", strm[0].busy, strm[0].en);
    end
  endtask

  task automatic test_back_to_back();
    run_feed(-1);
    checks++;
    if (en_cnt != FEED_LEN) begin errors++; $display("FAIL b2b_en_count got=%0d exp=%0d", en_cnt, FEED_LEN); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) row[k] = 8'(-(i + k + 1));
      load_row(1'b0, i, row);
      for (int k = 0; k < DIM; k++) row[k] = '0;
      load_row(1'b1, i, row);
    end
    run_feed(-1);
    checks++;
    if (strm[0].a[0 +: BW] !== 8'hFF) begin errors++; $display("FAIL neg_a0 got=%h exp=ff", strm[0].a[0 +: BW]); end
    checks++;
    if (strm[14].a[7*BW +: BW] !== 8'hF1) begin errors++; $display("FAIL neg_a7 got=%h exp=f1", strm[14].a[7*BW +: BW]); end
  endtask

  task automatic test_ignore_busy();
    for (int k = 0; k < DIM; k++) row[k] = 8'(k + 2);
    load_row(1'b0, 0, row);
    run_feed(5);
    checks++;
    if (en_cnt != FEED_LEN) begin errors++; $display("FAIL midfeed_len got=%0d exp=%0d", en_cnt, FEED_LEN); end
    run_feed(FEED_LEN);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy=%b exp=0", bus.busy); end
    @(negedge clk);
    run_feed(-1);
  endtask

  task automatic test_load_start_same();
    for (int k = 0; k < DIM; k++) row[k] = 8'(-5 * k - 3);
    bus.start = 1'b1;
    load_row(1'b0, 2, row);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL load_start_busy got=%b exp=0", bus.busy); end
    run_feed(-1);
  endtask

  task automatic test_reset_midfeed();
    obs_t got;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin errors++; $display("FAIL midfeed_reset got=%h exp=0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    run_feed(-1);
  endtask

  initial begin
    bus.ld_en  = 1'b0;
    bus.ld_sel = 1'b0;
    bus.ld_idx = '0;
    bus.start  = 1'b0;
    for (int k = 0; k < DIM; k++) bus.ld_data[k] = '0;
    clear_model();
    test_reset();
    test_basic();
    test_back_to_back();
    test_negative();
    test_ignore_busy();
    test_load_start_same();
    test_reset_midfeed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
